// File: rtl/repeat_id_pkg.sv
// Shared types and helpers for the repeated-pattern ID range scanner.
package repeat_id_pkg;

  localparam int W_DEFAULT      = 48;
  localparam int DIGITS_DEFAULT = 15;
  localparam int SUM_W_DEFAULT  = 64;
  localparam int CNT_W_DEFAULT  = 32;

  // Upper bound on digit count that the period table can describe.
  localparam int MAX_DIGITS = 31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONV   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  typedef enum logic {
    MODE_EXACT2   = 1'b0,
    MODE_ATLEAST2 = 1'b1
  } mode_t;

  typedef logic [3:0] bcd_digit_t;

  typedef bcd_digit_t [DIGITS_DEFAULT-1:0] digit_vec_t;

  // Divisor table: true when p is a proper divisor of an n-digit number's
  // length. The loop is over constant k, so with a constant p the table
  // collapses to a compare against n rather than a real divider.
  function automatic logic period_valid(input int n, input int p);
    logic r;
    r = 1'b0;
    for (int k = 2; k <= MAX_DIGITS; k++) begin
      if (k == n && p >= 1 && p < k && (k % p) == 0) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/repeat_id_range_scanner_check.sv
// Combinational repeated-pattern detector over a BCD digit vector.
module repeat_pattern_check
  import repeat_id_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  bcd_digit_t [DIGITS-1:0] digits,
  input  mode_t                   mode,
  output logic                    hit
);

  int   n;
  logic any_p;
  logic half_p;
  logic ok;

  // Find the significant length, then test every proper period of it.
  always_comb begin
    n      = 1;
    any_p  = 1'b0;
    half_p = 1'b0;
    ok     = 1'b0;
    for (int i = 1; i < DIGITS; i++) begin
      if (digits[i] != 4'd0) n = i + 1;
    end
    for (int p = 1; p < DIGITS; p++) begin
      ok = period_valid(n, p);
      for (int i = p; i < DIGITS; i++) begin
        if (i < n && digits[i] != digits[i-p]) ok = 1'b0;
      end
      if (ok) any_p = 1'b1;
      if (ok && (2 * p) == n) half_p = 1'b1;
    end
    hit = (mode == MODE_ATLEAST2) ? any_p : half_p;
  end

endmodule

// File: rtl/repeat_id_range_scanner.sv
// Streaming range scanner: converts the range start to BCD once, then walks
// the range one ID per cycle, summing and counting repeated-pattern IDs.
//
// state  | meaning
// IDLE   | waiting for a range; in_ready high
// CONV   | double-dabble of start into BCD, W cycles
// SCAN   | one ID per cycle into the checker stage
// DRAIN  | retire the last registered checker result
// RESULT | out_valid high, result held until out_ready
module repeat_id_range_scanner
  import repeat_id_pkg::*;
#(
  parameter int W      = W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT,
  parameter int SUM_W  = SUM_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_start,
  input  logic [W-1:0]     in_end,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic [SUM_W-1:0] total_sum,
  output logic [CNT_W-1:0] total_cnt,
  output logic             busy
);

  localparam int CW = $clog2(W);

  state_t                  state;
  state_t                  state_nx;
  logic [W-1:0]            end_q;
  logic [W-1:0]            cur_q;
  logic [W-1:0]            sh_q;
  mode_t                   mode_q;
  bcd_digit_t [DIGITS-1:0] bcd_q;
  bcd_digit_t [DIGITS-1:0] bcd_dd;
  bcd_digit_t [DIGITS-1:0] bcd_inc;
  logic [CW-1:0]           conv_cnt_q;
  logic                    hit_c;
  logic                    hit_q;
  logic [W-1:0]            id_q;
  logic                    tot_pend_q;
  logic [SUM_W-1:0]        range_sum_q;
  logic [CNT_W-1:0]        range_cnt_q;
  logic                    accept;
  logic                    at_end;
  logic                    conv_done;
  logic                    inc_carry;

  assign accept    = (state == ST_IDLE) && in_valid;
  assign at_end    = (cur_q == end_q);
  assign conv_done = (conv_cnt_q == '0);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (in_valid) state_nx = (in_start > in_end) ? ST_RESULT : ST_CONV;
      ST_CONV:   if (conv_done) state_nx = ST_SCAN;
      ST_SCAN:   if (at_end) state_nx = ST_DRAIN;
      ST_DRAIN:  state_nx = ST_RESULT;
      ST_RESULT: if (out_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_RESULT);
    busy      = (state != ST_IDLE);
  end

  // One double-dabble step: add-3 on digits >= 5, then shift left with the
  // next binary bit entering digit 0. The low 3 bits of d+3 equal d[2:0]+3
  // mod 8, and the bit shifted into the next digit is simply d >= 5.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      bcd_dd[i][3:1] = (bcd_q[i] >= 4'd5) ? (bcd_q[i][2:0] + 3'd3) : bcd_q[i][2:0];
      if (i == 0) bcd_dd[i][0] = sh_q[W-1];
      else        bcd_dd[i][0] = (bcd_q[i-1] >= 4'd5);
    end
  end

  // Decimal increment with a ripple carry across digits.
  always_comb begin
    inc_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_inc[i] = bcd_q[i];
      if (inc_carry) begin
        if (bcd_q[i] == 4'd9) begin
          bcd_inc[i] = 4'd0;
        end else begin
          bcd_inc[i] = bcd_q[i] + 4'd1;
          inc_carry  = 1'b0;
        end
      end
    end
  end

  // Range latch, BCD conversion and the lockstep binary/BCD cursor.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      end_q      <= '0;
      cur_q      <= '0;
      sh_q       <= '0;
      mode_q     <= MODE_EXACT2;
      bcd_q      <= '0;
      conv_cnt_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            end_q      <= in_end;
            mode_q     <= mode_t'(in_mode);
            cur_q      <= in_start;
            sh_q       <= in_start;
            bcd_q      <= '0;
            conv_cnt_q <= CW'(W - 1);
          end
        end
        ST_CONV: begin
          bcd_q <= bcd_dd;
          sh_q  <= sh_q << 1;
          if (!conv_done) conv_cnt_q <= conv_cnt_q - 1'b1;
        end
        ST_SCAN: begin
          if (!at_end) begin
            cur_q <= cur_q + 1'b1;
            bcd_q <= bcd_inc;
          end
        end
        default: ;
      endcase
    end
  end

  repeat_pattern_check #(
    .DIGITS (DIGITS)
  ) u_check (
    .digits (bcd_q),
    .mode   (mode_q),
    .hit    (hit_c)
  );

  // Checker pipeline stage; only SCAN cycles can produce a hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_q <= 1'b0;
      id_q  <= '0;
    end else begin
      hit_q <= (state == ST_SCAN) && hit_c;
      id_q  <= cur_q;
    end
  end

  // Per-range accumulators, cleared when a new range is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      range_sum_q <= '0;
      range_cnt_q <= '0;
    end else if (accept) begin
      range_sum_q <= '0;
      range_cnt_q <= '0;
    end else if (hit_q) begin
      range_sum_q <= range_sum_q + SUM_W'(id_q);
      range_cnt_q <= range_cnt_q + 1'b1;
    end
  end

  // Marks the first RESULT cycle so the totals are updated exactly once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) tot_pend_q <= 1'b0;
    else       tot_pend_q <= (state != ST_RESULT) && (state_nx == ST_RESULT);
  end

  // Running totals; a coincident clear drops that range's contribution.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      total_sum <= '0;
      total_cnt <= '0;
    end else if (clear) begin
      total_sum <= '0;
      total_cnt <= '0;
    end else if (tot_pend_q) begin
      total_sum <= total_sum + range_sum_q;
      total_cnt <= total_cnt + range_cnt_q;
    end
  end

  assign out_sum = range_sum_q;
  assign out_cnt = range_cnt_q;

endmodule

// File: tb/tb_repeat_id_range_scanner.sv
// Directed bench for repeat_id_range_scanner with a string-based model of
// the repeated-pattern rule and a per-cycle compare process.
module tb_repeat_id_range_scanner;

  localparam int W     = 48;
  localparam int SUM_W = 64;
  localparam int CNT_W = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_start;
  logic [W-1:0]     in_end;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic [SUM_W-1:0] total_sum;
  logic [CNT_W-1:0] total_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;
  bit run_checks = 0;

  longint unsigned m_sum;
  int unsigned     m_cnt;
  longint unsigned m_total_sum;
  int unsigned     m_total_cnt;

  repeat_id_range_scanner dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_start  (in_start),
    .in_end    (in_end),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .total_sum (total_sum),
    .total_cnt (total_cnt),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // An ID matches when its decimal text equals some proper prefix repeated.
  function automatic bit is_rep(input longint unsigned v, input bit mode);
    string s;
    string r;
    int n;
    bit found;
    s = $sformatf("%0d", v);
    n = s.len();
    found = 0;
    for (int p = 1; p < n; p++) begin
      if (n % p == 0) begin
        r = "";
        for (int k = 0; k < n / p; k++) r = {r, s.substr(0, p - 1)};
        if (r == s && (mode || (2 * p == n))) found = 1;
      end
    end
    return found;
  endfunction

  task automatic model_range(input longint unsigned s, input longint unsigned e, input bit mode,
                             output longint unsigned sum, output int unsigned cnt);
    sum = 0;
    cnt = 0;
    if (s <= e) begin
      for (longint unsigned v = s; v <= e; v++) begin
        if (is_rep(v, mode)) begin
          sum += v;
          cnt++;
        end
      end
    end
  endtask

  function automatic int exp_latency(input longint unsigned s, input longint unsigned e);
    if (s > e) return 1;
    return W + int'(e - s + 1) + 2;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (run_checks && !reset) begin
      check("total_sum", total_sum, m_total_sum);
      check("total_cnt", total_cnt, m_total_cnt);
      check("busy_vs_ready", busy, !in_ready);
      if (out_valid) begin
        check("out_sum_model", out_sum, m_sum);
        check("out_cnt_model", out_cnt, m_cnt);
      end
    end
  end

  task automatic send(input longint unsigned s, input longint unsigned e, input bit mode);
    @(negedge clock);
    check("in_ready_at_send", in_ready, 1);
    in_start = W'(s);
    in_end   = W'(e);
    in_mode  = mode;
    in_valid = 1'b1;
    model_range(s, e, mode, m_sum, m_cnt);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int lat_exp, input int stall,
                         input longint unsigned lit_sum, input longint unsigned lit_cnt,
                         input bit do_clear, input bit inject);
    int lat;
    bit seen;
    longint unsigned hs;
    longint unsigned hc;
    lat  = 1;
    seen = 0;
    while (lat <= lat_exp + 5) begin
      @(negedge clock);
      if (inject && lat == 5) begin
        in_valid = 1'b1;
        in_start = '0;
        in_end   = W'(200);
        in_mode  = 1'b1;
      end
      if (inject && lat == 7) in_valid = 1'b0;
      if (out_valid) begin
        seen = 1;
        break;
      end
      @(posedge clock);
      lat++;
    end
    in_valid = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for out_valid after %0d cycles", tag, lat);
      return;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_sum"}, out_sum, lit_sum);
    check({tag, "_cnt"}, out_cnt, lit_cnt);
    hs = out_sum;
    hc = out_cnt;
    if (do_clear) clear = 1'b1;
    out_ready = (stall == 0);
    @(posedge clock);
    #1;
    if (do_clear) begin
      clear = 1'b0;
      m_total_sum = 0;
      m_total_cnt = 0;
    end else begin
      m_total_sum += m_sum;
      m_total_cnt += m_cnt;
    end
    for (int k = 0; k < stall; k++) begin
      @(negedge clock);
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_sum"}, out_sum, hs);
      check({tag, "_stall_cnt"}, out_cnt, hc);
      if (k == stall - 1) out_ready = 1'b1;
      @(posedge clock);
      #1;
    end
    out_ready = 1'b0;
    @(negedge clock);
    check({tag, "_idle_after"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input longint unsigned s, input longint unsigned e, input bit mode,
                     input longint unsigned lit_sum, input longint unsigned lit_cnt);
    send(s, e, mode);
    collect(tag, exp_latency(s, e), 0, lit_sum, lit_cnt, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned ps;
    int unsigned pc;
    longint unsigned maxid;

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_start = '0; in_end = '0;
    in_mode = 1'b0; out_ready = 1'b0;
    m_sum = 0; m_cnt = 0; m_total_sum = 0; m_total_cnt = 0;

    // Pin the model against hand-computed values.
    model_range(11, 22, 0, ps, pc);          check("model_pin_11_22", ps, 33);
    model_range(95, 115, 1, ps, pc);         check("model_pin_95_115", ps, 210);
    model_range(998, 1012, 1, ps, pc);       check("model_pin_998_cnt", pc, 2);
    model_range(222220, 222224, 1, ps, pc);  check("model_pin_222222", ps, 222222);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_total_sum", total_sum, 0);
    reset = 1'b0;
    run_checks = 1;

    // First range, with a stray in_valid during CONV that must be ignored.
    send(11, 22, 0);
    collect("r11_22", 62, 0, 33, 2, 0, 1);

    run("r95_m0", 95, 115, 0, 99, 1);
    run("r95_m1", 95, 115, 1, 210, 2);
    run("r998_m0", 998, 1012, 0, 1010, 1);
    run("r998_m1", 998, 1012, 1, 2009, 2);
    run("r222220_m1", 222220, 222224, 1, 222222, 1);

    // Back-to-back with a stalled consumer, totals from a clean clear.
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    m_total_sum = 0;
    m_total_cnt = 0;
    send(11, 22, 0);
    collect("b2b_first", exp_latency(11, 22), 5, 33, 2, 0, 0);
    send(1188511880, 1188511890, 0);
    collect("b2b_second", exp_latency(1188511880, 1188511890), 0, 1188511885, 1, 0, 0);
    check("b2b_total_sum", total_sum, 1188511918);
    check("b2b_total_cnt", total_cnt, 3);

    // Empty and edge ranges.
    run("empty_30_20", 30, 20, 0, 0, 0);
    run("single_digits", 1, 9, 1, 0, 0);
    maxid = 64'h0000_FFFF_FFFF_FFFF;
    run("max_id", maxid, maxid, 1, 0, 0);
    run("after_max", 11, 22, 0, 33, 2);

    // Reset in the middle of a scan.
    send(95, 115, 0);
    repeat (W + 5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    m_total_sum = 0;
    m_total_cnt = 0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_out_cnt", out_cnt, 0);
    check("midrst_total_sum", total_sum, 0);
    check("midrst_total_cnt", total_cnt, 0);
    @(negedge clock);
    reset = 1'b0;
    run("post_rst", 11, 22, 0, 33, 2);

    // clear on the cycle the result appears drops its contribution.
    send(11, 22, 0);
    collect("clear_entry", exp_latency(11, 22), 0, 33, 2, 1, 0);
    check("clear_total_sum", total_sum, 0);
    check("clear_total_cnt", total_cnt, 0);

    repeat (2) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repeat_id_range_scanner.md
Name: repeat_id_range_scanner

Overview:
- Streaming successor to the fixed-array day2_puzzle engine. It accepts one ID range per valid/ready handshake and scans every ID in the range at one ID per cycle.
- It sums and counts "repeated-pattern" IDs, meaning the decimal digits are one block repeated. The repeat rule is chosen per range at runtime.
- Results return on an output handshake, and a running total accumulates across ranges. A top level can replicate N scanners behind a round-robin distributor, which replaces the parallel preload scheme.

Parameters:
- W, 48, ID width in bits.
- DIGITS, 15, BCD digit count. Must satisfy 10^DIGITS > 2^W-1.
- SUM_W, 64, width of the range sum and the total sum. Both wrap modulo 2^SUM_W.
- CNT_W, 32, width of the hit count. Wraps.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  synchronous clear of total_sum and total_cnt.
- in_valid  in  1  range offered.
- in_ready  out  1  scanner can accept a range.
- in_start  in  W  first ID, inclusive.
- in_end  in  W  last ID, inclusive.
- in_mode  in  1  0 = exactly two repeats; 1 = two or more repeats.
- out_valid  out  1  range result available.
- out_ready  in  1  consumer takes result.
- out_sum  out  SUM_W  sum of matching IDs in the range.
- out_cnt  out  CNT_W  number of matching IDs.
- total_sum  out  SUM_W  running sum since reset/clear.
- total_cnt  out  CNT_W  running count.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset value of every output register is 0; in_ready is 1 in IDLE.
- Reset asserted mid-operation aborts the scan, discards any pending result, and returns the FSM to IDLE.
- FSM states: IDLE, CONV, SCAN, DRAIN, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch start, end and mode. Clear the range accumulators.
  - If start>end, go to RESULT with sum=0 and cnt=0. The result is visible 1 cycle after the handshake.
  - Otherwise go to CONV.
- CONV:
  - Sequential double-dabble of start into DIGITS BCD digits, exactly W cycles, then go to SCAN.
  - Binary cursor cur := start.
- SCAN:
  - Each cycle, present (cur, BCD(cur)) to the checker stage.
  - If cur==end, go to DRAIN. Otherwise increment cur and the BCD counter in lockstep, with a decimal carry chain.
  - The end comparison happens before increment, so end = 2^W-1 must not wrap or overrun.
- Checker (1 registered stage, hit_q/id_q):
  - n = index of the most significant nonzero digit + 1; the value 0 has n=1.
  - Period p is valid iff p divides n, p<n, and digit[i]==digit[i-p] for all p<=i<n.
  - Mode 0: hit iff n is even and p=n/2 is valid.
  - Mode 1: hit iff any valid p exists. OR over all p, so an ID counts once even when several periods match.
  - On hit, the next cycle adds id_q to the range sum and increments the range count.
- DRAIN: 1 cycle to retire the last checker result, then go to RESULT.
- RESULT:
  - out_valid=1; out_sum and out_cnt are held stable until out_ready.
  - On the cycle of entry, add out_sum and out_cnt into the totals once.
  - On out_ready, go to IDLE.
  - in_ready=0 in every state except IDLE.
- Latency for a nonempty range of N=end-start+1 IDs:
  - Handshake in cycle 0.
  - CONV in cycles 1..W.
  - SCAN in cycles W+1..W+N.
  - DRAIN in cycle W+N+1.
  - out_valid is first high in cycle W+N+2.
- clear and a total update in the same cycle: clear wins and that range's contribution to the totals is dropped. out_sum and out_cnt are unaffected.
- in_valid while not in IDLE is ignored, with no side effects.

Decomposition:
- Package repeat_id_pkg holds:
  - the state enum;
  - the mode enum (MODE_EXACT2=0, MODE_ATLEAST2=1);
  - the BCD digit typedef (logic [3:0]);
  - the digit-vector typedef sized by DIGITS;
  - the divisor table function that returns the valid p<n for each n.
- Sub-module repeat_pattern_check: combinational digit-vector plus mode in, hit out. Its registered output lives in the parent.
- The double-dabble converter and the BCD incrementer stay inline in the parent.

Test Plan:
- Range 11..22, mode 0 -> out_sum=33, out_cnt=2. out_valid first high at cycle W+14=62 after the handshake.
- Range 95..115, mode 0 -> sum 99, cnt 1. The same range in mode 1 -> sum 210, cnt 2 (99 and 111).
- Range 998..1012 in mode 0 -> 1010, cnt 1. In mode 1 -> 2009, cnt 2. Range 222220..222224 in mode 1 -> 222222 counted once.
- Back-to-back ranges:
  - 11..22 then 1188511880..1188511890 (mode 0), with out_ready held low 5 cycles on the first.
  - Output stays stable during the stall.
  - total_sum = 1188511918, total_cnt = 3.
- Empty and edge ranges:
  - 30..20 -> sum 0, cnt 0, out_valid 1 cycle after the handshake.
  - 1..9 -> cnt 0.
  - start=end=2^W-1 -> terminates after 1 scan cycle with no wrap.
- Reset asserted mid-SCAN of 95..115 -> all outputs 0, FSM in IDLE. A fresh 11..22 then yields 33. clear coincident with RESULT entry -> totals 0.
